instruction_queue: RTL and testbench

Parametrised successor to the single-entry instruction register. It is a DEPTH-entry instruction queue with valid/ready handshakes on both sides and a synchronous flush. It splits the head instruction into opcode and data fields for the decode stage. It sits between the fetch source and decode, so fetch can run ahead of execution.

---
 rtl/instruction_queue.sv | 83 ++++++++
 tb/tb_instruction_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode, with valid/ready on both sides,
// a synchronous flush, and the head word split into opcode (low bits) and data fields.
module instruction_queue #(
    parameter int INSTR_W  = 8,
    parameter int OPCODE_W = 4,
    parameter int DEPTH    = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTR_W-1:0]            instruction,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OPCODE_W-1:0]           opcode,
    output logic [INSTR_W-OPCODE_W-1:0]   data,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               push;
    logic               pop;
    logic [INSTR_W-1:0] head;

    // in_ready ignores out_ready on purpose: a full queue never takes a word, even while popping.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wr_ptr] <= instruction;
        end
    end

    assign head = mem[rd_ptr];

    // Fields are forced to zero when empty so stale storage never leaks to decode.
    always_comb begin
        opcode = '0;
        data   = '0;
        if (out_valid) begin
            opcode = head[OPCODE_W-1:0];
            data   = head[INSTR_W-1:OPCODE_W];
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboard bench for instruction_queue: expected words are queued on accepted pushes
// and compared against opcode/data whenever decode consumes the head.
module tb_instruction_queue;

    localparam int INSTR_W  = 8;
    localparam int OPCODE_W = 4;
    localparam int DEPTH    = 4;

    logic                        clock;
    logic                        reset;
    logic                        in_valid;
    logic                        in_ready;
    logic [INSTR_W-1:0]          instruction;
    logic                        flush;
    logic                        out_valid;
    logic                        out_ready;
    logic [OPCODE_W-1:0]         opcode;
    logic [INSTR_W-OPCODE_W-1:0] data;
    logic [$clog2(DEPTH):0]      count;

    int passed = 0;
    int total  = 0;

    logic [INSTR_W-1:0] sb[$];
    logic [INSTR_W-1:0] popped[$];
    logic               last_push;

    instruction_queue #(
        .INSTR_W  (INSTR_W),
        .OPCODE_W (OPCODE_W),
        .DEPTH    (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .opcode      (opcode),
        .data        (data),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Check outputs against the model at the falling edge, then apply the model's update after the rising edge.
    task automatic tick();
        logic do_pop;
        logic do_push;
        logic do_flush;
        logic [INSTR_W-1:0] word;
        @(negedge clock);
        check("out_valid", out_valid, sb.size() != 0);
        check("in_ready", in_ready, sb.size() != DEPTH);
        check("count", count, sb.size());
        if (sb.size() != 0) begin
            check("head_opcode", opcode, sb[0][OPCODE_W-1:0]);
            check("head_data", data, sb[0][INSTR_W-1:OPCODE_W]);
        end else begin
            check("empty_opcode", opcode, 0);
            check("empty_data", data, 0);
        end
        do_flush = flush;
        do_pop   = (sb.size() != 0) && out_ready;
        do_push  = (sb.size() != DEPTH) && in_valid;
        word     = instruction;
        @(posedge clock);
        #1;
        last_push = 1'b0;
        if (do_flush) begin
            sb.delete();
        end else begin
            if (do_pop) popped.push_back(sb.pop_front());
            if (do_push) begin
                sb.push_back(word);
                last_push = 1'b1;
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        instruction = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        last_push   = 1'b0;

        // Reset state
        #2;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Single push, field split
        in_valid = 1'b1; instruction = 8'b01001111;
        tick();
        in_valid = 1'b0;
        check("first_out_valid", out_valid, 1);
        check("first_opcode", opcode, 4'hF);
        check("first_data", data, 4'h4);
        check("first_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("first_popped", popped.size() == 1 ? popped[0] : 8'hxx, 8'h4F);

        // Fill to DEPTH, then a held push must be refused
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; instruction = 8'(8'h10 + 8'h11 * i);
            tick();
        end
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        instruction = 8'h54;
        for (int i = 0; i < 3; i++) tick();
        check("held_count", count, 4);
        check("held_opcode", opcode, 0);
        check("held_data", data, 1);

        // Drain while the source holds 8'h54 until it is accepted
        popped.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_push) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("drain_pops", popped.size(), 5);
        for (int i = 0; i < 5 && i < popped.size(); i++)
            check("drain_order_opcode", popped[i][3:0], i);
        check("drain_count", count, 0);

        // Streaming at one word per cycle
        popped.delete();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            instruction = 8'(i);
            tick();
            if (count != 1) check("stream_count", count, 1);
        end
        check("stream_count_end", count, 1);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("stream_len", popped.size(), 256);
        for (int i = 0; i < 256 && i < popped.size(); i++)
            if (popped[i] != 8'(i)) check("stream_order", popped[i], i);

        // Flush overrides push and pop
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; instruction = 8'(i);
            tick();
        end
        check("pre_flush_count", count, 3);
        flush = 1'b1; in_valid = 1'b1; instruction = 8'hAA; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_opcode", opcode, 0);
        check("flush_data", data, 0);
        in_valid = 1'b1; instruction = 8'h5B;
        tick();
        in_valid = 1'b0;
        check("post_flush_opcode", opcode, 4'hB);
        check("post_flush_data", data, 4'h5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset between edges
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; instruction = 8'(8'hC0 + i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_count", count, 2);
        #2;
        reset = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_out_valid", out_valid, 0);
        check("async_in_ready", in_ready, 1);
        check("async_opcode", opcode, 0);
        sb.delete();
        reset = 1'b1;
        in_valid = 1'b1; instruction = 8'h37;
        tick();
        in_valid = 1'b0;
        check("post_reset_count", count, 1);
        check("post_reset_opcode", opcode, 4'h7);
        check("post_reset_data", data, 4'h3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
